// File: rtl/subneg_mem_arbiter.sv
// Single-port memory arbiter between the SUBNEG core and the host debug/loader port.
// Round-robin on contention, bounded host lock bursts, 1-cycle read data routed to the issuer.
module subneg_mem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_lock,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    YIELD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;  // 1 = host granted last
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             dbg_rvalid_q, dbg_rvalid_d;
  logic             cpu_gnt_c, dbg_gnt_c;
  logic             use_arb, arb_last;

  always_comb begin
    cpu_gnt_c  = 1'b0;
    dbg_gnt_c  = 1'b0;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    use_arb    = 1'b0;
    arb_last   = last_gnt_q;

    case (state_q)
      ARB: use_arb = 1'b1;
      LOCK: begin
        // Releasing the lock falls straight through to arbitration, host counted as last owner
        if (!dbg_lock) begin
          use_arb  = 1'b1;
          arb_last = 1'b1;
        end else if (lock_cnt_q == MAX_CNT) begin
          state_d = YIELD;
        end else if (dbg_req) begin
          dbg_gnt_c  = 1'b1;
          last_gnt_d = 1'b1;
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      YIELD: begin
        cpu_gnt_c  = cpu_req;
        state_d    = ARB;
        lock_cnt_d = '0;
        last_gnt_d = 1'b0;
      end
      default: state_d = ARB;
    endcase

    if (use_arb) begin
      state_d    = ARB;
      lock_cnt_d = '0;
      if (cpu_req && (!dbg_req || arb_last)) begin
        cpu_gnt_c  = 1'b1;
        last_gnt_d = 1'b0;
      end else if (dbg_req) begin
        dbg_gnt_c  = 1'b1;
        last_gnt_d = 1'b1;
        if (dbg_lock) begin
          state_d    = LOCK;
          lock_cnt_d = CNT_W'(1);
        end
      end
    end

    if (reset) begin
      cpu_gnt_c  = 1'b0;
      dbg_gnt_c  = 1'b0;
      state_d    = ARB;
      last_gnt_d = 1'b1;
      lock_cnt_d = '0;
    end

    cpu_rvalid_d = cpu_gnt_c && !cpu_we;
    dbg_rvalid_d = dbg_gnt_c && !dbg_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      last_gnt_q   <= 1'b1;
      lock_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  // A read granted just before reset must not report data while reset is held
  assign cpu_rvalid = cpu_rvalid_q && !reset;
  assign dbg_rvalid = dbg_rvalid_q && !reset;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  assign cpu_gnt = cpu_gnt_c;
  assign dbg_gnt = dbg_gnt_c;
  assign mem_en  = cpu_gnt_c || dbg_gnt_c;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt_c) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt_c) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

endmodule

// File: tb/tb_subneg_mem_arbiter.sv
// Directed and randomised checks of subneg_mem_arbiter against a behavioural memory.
module tb_subneg_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       cpu_req, cpu_we;
  logic [5:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       dbg_req, dbg_lock, dbg_we;
  logic [5:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic       mem_en, mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  logic [7:0] rd_q;
  logic       mem_init;

  subneg_mem_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        rd_q <= mem[mem_addr];
    end
  end
  assign mem_rdata = rd_q;

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_lock = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    dbg_req = 1; dbg_we = 1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1) begin
      errors++; $display("FAIL host_write_gnt: got %b expected 1", dbg_gnt);
    end
    next();
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_en, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b expected 0000", {cpu_gnt, dbg_gnt, mem_en, mem_we});
    end
    next();
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, mem_addr} !== 24'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0",
                         {cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, mem_addr});
    end
    next();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid} !== 5'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 00000",
                         {cpu_gnt, dbg_gnt, mem_en, cpu_rvalid, dbg_rvalid});
    end
    next();
  endtask

  task automatic test_cpu_read();
    do_reset();
    host_write(6'd5, 8'd20);
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd5;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 6'd5}) begin
      errors++; $display("FAIL cpu_read_gnt: got %b expected %b",
                         {cpu_gnt, dbg_gnt, mem_en, mem_we, mem_addr}, {4'b1010, 6'd5});
    end
    next();
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'd20}) begin
      errors++; $display("FAIL cpu_read_data: got %b/%0d expected 1/20", cpu_rvalid, cpu_rdata);
    end
    checks++;
    if ({dbg_rvalid, dbg_rdata, dbg_gnt} !== 10'b0) begin
      errors++; $display("FAIL cpu_read_dbg_quiet: got %b/%0d/%b expected 0/0/0",
                         dbg_rvalid, dbg_rdata, dbg_gnt);
    end
    next();
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== 9'b0) begin
      errors++; $display("FAIL cpu_rvalid_single: got %b/%0d expected 0/0", cpu_rvalid, cpu_rdata);
    end
    next();
  endtask

  task automatic test_round_robin();
    do_reset();
    host_write(6'd10, 8'h11);
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd10;
    dbg_req = 1; dbg_we = 1; dbg_addr = 6'd3; dbg_wdata = 8'h7F;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      errors++; $display("FAIL rr_slot0: got %b expected 10", {cpu_gnt, dbg_gnt});
    end
    next();
    cpu_addr = 6'd3;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_we, mem_addr, mem_wdata} !== {3'b011, 6'd3, 8'h7F}) begin
      errors++; $display("FAIL rr_slot1_host_write: got %h expected %h",
                         {cpu_gnt, dbg_gnt, mem_we, mem_addr, mem_wdata}, {3'b011, 6'd3, 8'h7F});
    end
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h11}) begin
      errors++; $display("FAIL rr_cpu_rdata10: got %b/%h expected 1/11", cpu_rvalid, cpu_rdata);
    end
    next();
    dbg_we = 0;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, dbg_rvalid} !== 3'b100) begin
      errors++; $display("FAIL rr_slot2: got %b expected 100", {cpu_gnt, dbg_gnt, dbg_rvalid});
    end
    next();
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
      errors++; $display("FAIL rr_slot3: got %b expected 01", {cpu_gnt, dbg_gnt});
    end
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h7F}) begin
      errors++; $display("FAIL rr_cpu_rdata3: got %b/%h expected 1/7f", cpu_rvalid, cpu_rdata);
    end
    next();
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      errors++; $display("FAIL rr_slot4: got %b expected 10", {cpu_gnt, dbg_gnt});
    end
    checks++;
    if ({dbg_rvalid, dbg_rdata, cpu_rvalid} !== {1'b1, 8'h7F, 1'b0}) begin
      errors++; $display("FAIL rr_dbg_rdata3: got %b/%h/%b expected 1/7f/0",
                         dbg_rvalid, dbg_rdata, cpu_rvalid);
    end
    next();
    clear_inputs();
    next();
  endtask

  task automatic test_lock_burst();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'd40; cpu_wdata = 8'd1;
    dbg_req = 1; dbg_lock = 1; dbg_we = 1; dbg_addr = 6'd50; dbg_wdata = 8'd2;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      errors++; $display("FAIL lock_first_tie: got %b expected 10", {cpu_gnt, dbg_gnt});
    end
    next();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
        errors++; $display("FAIL lock_burst_%0d: got %b expected 01", i, {cpu_gnt, dbg_gnt});
      end
      next();
    end
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_en} !== 3'b000) begin
      errors++; $display("FAIL lock_gap: got %b expected 000", {cpu_gnt, dbg_gnt, mem_en});
    end
    next();
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_addr} !== {2'b10, 6'd40}) begin
      errors++; $display("FAIL lock_yield_cpu: got %b expected %b", {cpu_gnt, dbg_gnt, mem_addr},
                         {2'b10, 6'd40});
    end
    next();
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
      errors++; $display("FAIL lock_rewin: got %b expected 01", {cpu_gnt, dbg_gnt});
    end
    next();
    clear_inputs();
    next();
  endtask

  task automatic test_lock_idle();
    do_reset();
    dbg_req = 1; dbg_lock = 1; dbg_we = 1; dbg_addr = 6'd7; dbg_wdata = 8'd9;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
      errors++; $display("FAIL idle_lock_win: got %b expected 01", {cpu_gnt, dbg_gnt});
    end
    next();
    dbg_req = 0; dbg_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({cpu_gnt, dbg_gnt, mem_en} !== 3'b000) begin
        errors++; $display("FAIL idle_lock_hold_%0d: got %b expected 000", i, {cpu_gnt, dbg_gnt, mem_en});
      end
      next();
    end
    dbg_lock = 0;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      errors++; $display("FAIL idle_lock_release: got %b expected 10", {cpu_gnt, dbg_gnt});
    end
    next();
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'd9}) begin
      errors++; $display("FAIL idle_lock_rdata: got %b/%0d expected 1/9", cpu_rvalid, cpu_rdata);
    end
    next();
  endtask

  task automatic test_reset_drop();
    do_reset();
    dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 6'd21;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b01) begin
      errors++; $display("FAIL rd_host_gnt: got %b expected 01", {cpu_gnt, dbg_gnt});
    end
    next();
    reset = 1;
    dbg_req = 0;
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, dbg_rdata} !== 9'b0) begin
      errors++; $display("FAIL rd_rvalid_dropped: got %b/%0d expected 0/0", dbg_rvalid, dbg_rdata);
    end
    next();
    next();
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'd1;
    dbg_req = 1; dbg_lock = 1; dbg_we = 0; dbg_addr = 6'd2;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10) begin
      errors++; $display("FAIL rd_tie_after_reset: got %b expected 10", {cpu_gnt, dbg_gnt});
    end
    next();
    clear_inputs();
    next();
  endtask

  task automatic test_random();
    logic [7:0] shadow [64];
    logic       cg, dg, exp_crv, exp_drv;
    logic [7:0] exp_cd, exp_dd;
    int         cpu_wait;
    do_reset();
    mem_init = 1;
    next();
    mem_init = 0;
    for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
    cg = 1; dg = 1; exp_crv = 0; exp_drv = 0; exp_cd = 0; exp_dd = 0; cpu_wait = 0;
    for (int n = 0; n < 3000; n++) begin
      if (cg || !cpu_req || $urandom_range(0, 15) == 0) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 6'($urandom_range(0, 63));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      if (dg || !dbg_req || $urandom_range(0, 15) == 0) begin
        dbg_req   = ($urandom_range(0, 3) != 0);
        dbg_lock  = dbg_req && ($urandom_range(0, 1) == 1);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 6'($urandom_range(0, 63));
        dbg_wdata = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      checks++;
      if ((cpu_gnt && dbg_gnt) || (cpu_gnt && !cpu_req) || (dbg_gnt && !dbg_req)) begin
        errors++; $display("FAIL rnd_gnt_legal: got gnt %b req %b at cycle %0d",
                           {cpu_gnt, dbg_gnt}, {cpu_req, dbg_req}, n);
      end
      checks++;
      if (cpu_gnt) begin
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, cpu_we, cpu_addr, cpu_wdata}) begin
          errors++; $display("FAIL rnd_mux_cpu: got %h expected %h", {mem_en, mem_we, mem_addr, mem_wdata},
                             {1'b1, cpu_we, cpu_addr, cpu_wdata});
        end
      end else if (dbg_gnt) begin
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, dbg_we, dbg_addr, dbg_wdata}) begin
          errors++; $display("FAIL rnd_mux_dbg: got %h expected %h", {mem_en, mem_we, mem_addr, mem_wdata},
                             {1'b1, dbg_we, dbg_addr, dbg_wdata});
        end
      end else if ({mem_en, mem_we, mem_addr, mem_wdata} !== 16'h0) begin
        errors++; $display("FAIL rnd_mux_idle: got %h expected 0", {mem_en, mem_we, mem_addr, mem_wdata});
      end
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {exp_crv, exp_crv ? exp_cd : 8'h00}) begin
        errors++; $display("FAIL rnd_cpu_read: got %b/%h expected %b/%h at cycle %0d",
                           cpu_rvalid, cpu_rdata, exp_crv, exp_crv ? exp_cd : 8'h00, n);
      end
      checks++;
      if ({dbg_rvalid, dbg_rdata} !== {exp_drv, exp_drv ? exp_dd : 8'h00}) begin
        errors++; $display("FAIL rnd_dbg_read: got %b/%h expected %b/%h at cycle %0d",
                           dbg_rvalid, dbg_rdata, exp_drv, exp_drv ? exp_dd : 8'h00, n);
      end
      exp_crv = cpu_gnt && !cpu_we;
      exp_drv = dbg_gnt && !dbg_we;
      exp_cd  = shadow[cpu_addr];
      exp_dd  = shadow[dbg_addr];
      if (cpu_gnt && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (dbg_gnt && dbg_we) shadow[dbg_addr] = dbg_wdata;
      if (cpu_req && !cpu_gnt) cpu_wait++;
      else cpu_wait = 0;
      checks++;
      if (cpu_wait > 10) begin
        errors++; $display("FAIL rnd_cpu_starved: got wait %0d expected <= 10 at cycle %0d", cpu_wait, n);
      end
      cg = cpu_gnt;
      dg = dbg_gnt;
      next();
    end
    clear_inputs();
    next();
    next();
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== shadow[i]) begin
        errors++; $display("FAIL rnd_mem_%0d: got %h expected %h", i, mem[i], shadow[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    clear_inputs();
    test_reset();
    mem_init = 1'b0;
    test_cpu_read();
    test_round_robin();
    test_lock_burst();
    test_lock_idle();
    test_reset_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
